pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline-stage register for the core pipeline, generalising the fixed-field stage registers between decode and execute. It carries an opaque DW-bit payload with a valid/ready handshake, a hold input that freezes the stage, and a flush input that turns all contents into bubbles. An optional second (skid) entry makes `in_ready_o` a pure register output, breaking the combinational ready path through the pipeline.

## Interface
Parameters:
- `DW`, 32: payload width in bits.
- `NOP_VAL`, 0: payload value presented on `out_data_o` after reset, after flush, and whenever the stage is empty.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discard all entries at the next edge.
- `hold_i`  in  1  freeze the stage: no accept, no emit, contents kept.
- `in_valid_i`  in  1  upstream payload valid.
- `in_ready_o`  out  1  stage can accept.
- `in_data_i`  in  DW  upstream payload.
- `out_valid_o`  out  1  main entry valid, masked by hold.
- `out_ready_i`  in  1  downstream can accept.
- `out_data_o`  out  DW  main-entry payload.
- `occupancy_o`  out  2  number of valid entries: 0, 1 or 2.

## Operation
- State:
  - main entry M (`m_valid`, `m_data`);
  - skid entry S (`s_valid`, `s_data`), which exists only with the skid feature.
- `out_data_o` = `m_data`.
- `out_valid_o` = `m_valid & ~hold_i`.
- Accept = `in_valid_i & in_ready_o`. Emit = `out_valid_o & out_ready_i`.
- Update priority, highest first: `rst`, then `flush_i`, then `hold_i`, then the normal update.
- On `rst` or `flush_i`:
  - `m_valid` = `s_valid` = 0;
  - `m_data` = `s_data` = `NOP_VAL`;
  - any input presented in the same cycle is dropped.
- While `hold_i` is high (and no flush):
  - `in_ready_o` = 0 and `out_valid_o` = 0;
  - all state is unchanged.
- Normal update, with skid:
  - Emit and S valid: S moves to M; S is cleared; an accept is impossible in this cycle (`in_ready_o` = 0).
  - Accept, and M is empty or emitting: payload goes to M.
  - Accept, and M is valid but not emitting: payload goes to S (`s_valid` = 1).
  - Emit, no accept, S empty: `m_valid` = 0 and `m_data` = `NOP_VAL`.
  - Otherwise: state is held.
- `in_ready_o` (skid) = `~s_valid & ~hold_i`. No combinational path from `out_ready_i`.
- Order is preserved: M always holds the oldest entry and is never overwritten while valid and not emitting.

## Timing
- Reset values: `out_valid_o` = 0, `in_ready_o` = 1 (when `hold_i` = 0), `out_data_o` = `NOP_VAL`, `occupancy_o` = 0.
- Latency: a payload accepted at edge N appears on `out_valid_o`/`out_data_o` after edge N, i.e. 1 cycle.
- Throughput: 1 transfer per cycle with `out_ready_i` held high.
- With skid: after a stall that fills S, `in_ready_o` deasserts the cycle after S fills. It reasserts one cycle after the emit that drains S.
- Full (skid): `occupancy_o` = 2 and `in_ready_o` = 0.
- Empty: `out_valid_o` = 0 and `out_data_o` = `NOP_VAL`.
- Flush during hold: the flush takes effect and `hold_i` is ignored for that edge.
- Reset asserted mid-transfer: the transfer is lost and the stage is empty after the edge.

## Configuration
- `PIPE_SKID_EN` defined:
  - S entry present;
  - `in_ready_o` registered as above;
  - `occupancy_o` ranges 0–2.
- `PIPE_SKID_EN` undefined:
  - single entry M only;
  - `in_ready_o` = `~hold_i & (~m_valid | out_ready_i)`, which is combinational from `out_ready_i`;
  - an accept while M is emitting replaces M in the same edge;
  - `occupancy_o[1]` is tied 0.
- Latency, flush, hold and reset behaviour are identical in both builds.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with `out_ready_i` = 1 → outputs 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after accept; `occupancy_o` = 1 throughout.
- Skid build: `out_ready_i` = 0, offer 0xA1 then 0xA2 then 0xA3 → 0xA1 and 0xA2 accepted, `occupancy_o` = 2, `in_ready_o` = 0, 0xA3 stalls. Raise `out_ready_i` → order 0xA1, 0xA2, 0xA3; nothing lost or duplicated.
- Two entries held, assert `hold_i` for 3 cycles with `out_ready_i` = 1 → `out_valid_o` = 0 and `in_ready_o` = 0 for 3 cycles; state intact; release → 0xA1 emitted next.
- Two entries held, pulse `flush_i` together with `in_valid_i` = 1 (data 0x55) → next cycle `occupancy_o` = 0, `out_data_o` = `NOP_VAL`; 0x55 never appears.
- `flush_i` and `hold_i` both high → flush wins; stage empty after the edge.
- Assert `rst` while full → after the edge `out_valid_o` = 0, `occupancy_o` = 0, `out_data_o` = `NOP_VAL`, `in_ready_o` = 1.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage register with hold and flush.
// Define PIPE_SKID_EN to add a skid entry so that in_ready_o comes straight from a register.
module pipe_skid_stage #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   NOP_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          hold_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    occupancy_o
);

  logic          mValid_q, mValid_d;
  logic [DW-1:0] mData_q, mData_d;
  logic          accept, emit;

  assign out_valid_o = mValid_q & ~hold_i;
  assign out_data_o  = mData_q;
  assign emit        = out_valid_o & out_ready_i;
  assign accept      = in_valid_i & in_ready_o;

`ifdef PIPE_SKID_EN
  logic          sValid_q, sValid_d;
  logic [DW-1:0] sData_q, sData_d;

  assign in_ready_o  = ~sValid_q & ~hold_i;
  assign occupancy_o = {1'b0, mValid_q} + {1'b0, sValid_q};

  // M always holds the oldest entry; S only fills when M is stalled.
  always_comb begin
    mValid_d = mValid_q;
    mData_d  = mData_q;
    sValid_d = sValid_q;
    sData_d  = sData_q;
    if (flush_i) begin
      mValid_d = 1'b0;
      mData_d  = NOP_VAL;
      sValid_d = 1'b0;
      sData_d  = NOP_VAL;
    end else if (!hold_i) begin
      if (emit && sValid_q) begin
        mValid_d = 1'b1;
        mData_d  = sData_q;
        sValid_d = 1'b0;
        sData_d  = NOP_VAL;
      end else if (accept && (!mValid_q || emit)) begin
        mValid_d = 1'b1;
        mData_d  = in_data_i;
      end else if (accept) begin
        sValid_d = 1'b1;
        sData_d  = in_data_i;
      end else if (emit) begin
        mValid_d = 1'b0;
        mData_d  = NOP_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mValid_q <= 1'b0;
      mData_q  <= NOP_VAL;
      sValid_q <= 1'b0;
      sData_q  <= NOP_VAL;
    end else begin
      mValid_q <= mValid_d;
      mData_q  <= mData_d;
      sValid_q <= sValid_d;
      sData_q  <= sData_d;
    end
  end
`else
  // Single entry: ready looks through to downstream so M can be replaced while emitting.
  assign in_ready_o  = ~hold_i & (~mValid_q | out_ready_i);
  assign occupancy_o = {1'b0, mValid_q};

  always_comb begin
    mValid_d = mValid_q;
    mData_d  = mData_q;
    if (flush_i) begin
      mValid_d = 1'b0;
      mData_d  = NOP_VAL;
    end else if (!hold_i) begin
      if (accept) begin
        mValid_d = 1'b1;
        mData_d  = in_data_i;
      end else if (emit) begin
        mValid_d = 1'b0;
        mData_d  = NOP_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mValid_q <= 1'b0;
      mData_q  <= NOP_VAL;
    end else begin
      mValid_q <= mValid_d;
      mData_q  <= mData_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed self-checking bench for pipe_skid_stage.
// Covers both builds; skid-only sequences are selected by PIPE_SKID_EN.
module tb_pipe_skid_stage;

  localparam int            DW  = 8;
  localparam logic [DW-1:0] NOP = 8'hEE;

  logic          clk;
  logic          rst;
  logic          flushIn;
  logic          holdIn;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [1:0]    occupancy;

  int errorCount = 0;
  int checkCount = 0;

  pipe_skid_stage #(.DW(DW), .NOP_VAL(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flushIn),
    .hold_i      (holdIn),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (inData),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .occupancy_o (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic h,
                               input logic v, input logic [DW-1:0] d, input logic rdy);
    rst      = r;
    flushIn  = f;
    holdIn   = h;
    inValid  = v;
    inData   = d;
    outReady = rdy;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 8'h00, 0);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_out_data", outData, NOP);
    checkOutput("reset_occupancy", occupancy, 0);

    // Streaming at full rate, one cycle latency.
    applyStimulus(0, 0, 0, 1, 8'h11, 1);
    stepClock();
    checkOutput("stream_valid_11", outValid, 1);
    checkOutput("stream_data_11", outData, 8'h11);
    checkOutput("stream_occ_11", occupancy, 1);
    applyStimulus(0, 0, 0, 1, 8'h22, 1);
    stepClock();
    checkOutput("stream_data_22", outData, 8'h22);
    checkOutput("stream_occ_22", occupancy, 1);
    applyStimulus(0, 0, 0, 1, 8'h33, 1);
    stepClock();
    checkOutput("stream_data_33", outData, 8'h33);
    checkOutput("stream_occ_33", occupancy, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    stepClock();
    checkOutput("drain_valid", outValid, 0);
    checkOutput("drain_data", outData, NOP);
    checkOutput("drain_occ", occupancy, 0);

`ifdef PIPE_SKID_EN
    // Stall downstream: A1 in M, A2 in S, A3 stalls.
    applyStimulus(0, 0, 0, 1, 8'hA1, 0);
    stepClock();
    checkOutput("skid_occ_a1", occupancy, 1);
    applyStimulus(0, 0, 0, 1, 8'hA2, 0);
    checkOutput("skid_ready_a2", inReady, 1);
    stepClock();
    applyStimulus(0, 0, 0, 1, 8'hA3, 0);
    checkOutput("skid_full_occ", occupancy, 2);
    checkOutput("skid_full_ready", inReady, 0);
    stepClock();
    checkOutput("skid_stall_occ", occupancy, 2);
    checkOutput("skid_stall_data", outData, 8'hA1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 8'hA3, 1);
      checkOutput("hold_out_valid", outValid, 0);
      checkOutput("hold_in_ready", inReady, 0);
      stepClock();
    end
    checkOutput("hold_occ_kept", occupancy, 2);
    applyStimulus(0, 0, 0, 1, 8'hA3, 1);
    checkOutput("release_valid", outValid, 1);
    checkOutput("release_data_a1", outData, 8'hA1);
    checkOutput("release_ready", inReady, 0);
    stepClock();
    checkOutput("order_data_a2", outData, 8'hA2);
    checkOutput("order_occ_a2", occupancy, 1);
    checkOutput("order_ready_a2", inReady, 1);
    stepClock();
    checkOutput("order_data_a3", outData, 8'hA3);
    checkOutput("order_occ_a3", occupancy, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    stepClock();
    checkOutput("order_empty", outValid, 0);

    // Flush a full stage together with a new offer.
    applyStimulus(0, 0, 0, 1, 8'hB1, 0);
    stepClock();
    applyStimulus(0, 0, 0, 1, 8'hB2, 0);
    stepClock();
    checkOutput("preflush_occ", occupancy, 2);
`else
    // Single entry: stalled M blocks input; hold freezes it.
    applyStimulus(0, 0, 0, 1, 8'hA1, 0);
    stepClock();
    applyStimulus(0, 0, 0, 1, 8'hA2, 0);
    checkOutput("single_ready_stalled", inReady, 0);
    checkOutput("single_occ", occupancy, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 8'hA2, 1);
      checkOutput("hold_out_valid", outValid, 0);
      checkOutput("hold_in_ready", inReady, 0);
      stepClock();
    end
    applyStimulus(0, 0, 0, 1, 8'hA2, 1);
    checkOutput("release_valid", outValid, 1);
    checkOutput("release_data_a1", outData, 8'hA1);
    checkOutput("release_ready", inReady, 1);
    stepClock();
    checkOutput("replace_data_a2", outData, 8'hA2);
    checkOutput("replace_occ", occupancy, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    stepClock();
    checkOutput("single_empty", outValid, 0);

    applyStimulus(0, 0, 0, 1, 8'hB1, 0);
    stepClock();
    checkOutput("preflush_occ", occupancy, 1);
`endif

    applyStimulus(0, 1, 0, 1, 8'h55, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    checkOutput("flush_occ", occupancy, 0);
    checkOutput("flush_data", outData, NOP);
    checkOutput("flush_valid", outValid, 0);
    stepClock();
    checkOutput("flush_no_55_valid", outValid, 0);
    checkOutput("flush_no_55_data", outData, NOP);

    // Flush and hold together: flush wins.
    applyStimulus(0, 0, 0, 1, 8'hC1, 0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 8'h00, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 8'h00, 0);
    checkOutput("flush_hold_occ", occupancy, 0);
    checkOutput("flush_hold_data", outData, NOP);

    // Reset while occupied, with a transfer in flight.
    applyStimulus(0, 0, 0, 1, 8'hD1, 0);
    stepClock();
`ifdef PIPE_SKID_EN
    applyStimulus(0, 0, 0, 1, 8'hD2, 0);
    stepClock();
`endif
    applyStimulus(1, 0, 0, 1, 8'hD3, 1);
    stepClock();
    applyStimulus(0, 0, 0, 0, 8'h00, 0);
    checkOutput("rst_full_valid", outValid, 0);
    checkOutput("rst_full_occ", occupancy, 0);
    checkOutput("rst_full_data", outData, NOP);
    checkOutput("rst_full_ready", inReady, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
